// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage around the PC register.
// Issues sequential fetch requests (address = PC) under a credit limit of
// DEPTH (buffered words + outstanding requests), buffers returned words with
// their addresses in a DEPTH-entry FIFO, and produces next_PC. A redirect
// flushes the FIFO and marks every still-outstanding response for discard.
// DEPTH must be a power of two (pointers wrap by natural overflow), >= 2.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  output logic [31:0] o_next_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_instr,
  output logic [31:0] o_out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // FIFO storage: instruction word and its fetch address per entry
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [31:0]   r_resp_pc;

  logic [CW:0]   w_credit_used;
  logic          w_credit;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_accept_inc;
  logic [CW-1:0] w_resp_dec;
  logic [CW-1:0] w_push_inc;
  logic [CW-1:0] w_pop_dec;

  // Credit covers both words already buffered and words still in flight,
  // so a response can never land in a full FIFO.
  assign w_credit_used    = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit         = w_credit_used < (CW+1)'(DEPTH);
  assign o_imem_req_valid = !i_redirect && w_credit;
  assign o_imem_req_addr  = i_pc;
  assign w_accept         = o_imem_req_valid && i_imem_req_ready;

  assign o_next_pc = i_redirect ? i_redirect_pc :
                     (w_accept ? i_pc + 32'd4 : i_pc);

  // No bypass: the head is read straight from storage once count is non-zero.
  assign o_out_valid = (r_count != '0);
  assign o_out_instr = r_instr_mem[r_rd_ptr];
  assign o_out_pc    = r_pc_mem[r_rd_ptr];

  // A redirect cancels any pop or push in the same cycle.
  assign w_pop  = o_out_valid && i_out_ready && !i_redirect;
  assign w_push = i_imem_resp_valid && (r_discard == '0) && !i_redirect;

  assign w_accept_inc = w_accept          ? CNT_ONE : '0;
  assign w_resp_dec   = i_imem_resp_valid ? CNT_ONE : '0;
  assign w_push_inc   = w_push            ? CNT_ONE : '0;
  assign w_pop_dec    = w_pop             ? CNT_ONE : '0;

  // Write kept responses with their address into the FIFO slot at wr_ptr
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= i_imem_resp_data;
      r_pc_mem[r_wr_ptr]    <= r_resp_pc;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= r_count + w_push_inc - w_pop_dec;
    end
  end

  // Track in-flight requests and how many of their responses must be dropped
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      // No request is accepted during a redirect, so one formula serves both.
      r_outstanding <= r_outstanding + w_accept_inc - w_resp_dec;
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_discard <= r_outstanding - w_resp_dec;
      end else if (i_imem_resp_valid && (r_discard != '0)) begin
        r_discard <= r_discard - CNT_ONE;
      end
    end
  end

  // Address tag for the next kept response; restarts at the redirect target
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_resp_pc <= '0;
    end else if (i_redirect) begin
      r_resp_pc <= i_redirect_pc;
    end else if (w_push) begin
      r_resp_pc <= r_resp_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. The bench owns the PC register and a fixed-latency
// in-order memory; expected outputs come from a transaction-level model where
// every request is tagged with a fetch epoch, a redirect starts a new epoch,
// and only responses of the current epoch enter the expected output queue.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_pc;
  logic [31:0] o_next_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_resp_valid;
  logic [31:0] i_imem_resp_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_instr;
  logic [31:0] o_out_pc;

  always #5 i_clock = ~i_clock;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_pc             (i_pc),
    .o_next_pc        (o_next_pc),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_resp_valid(i_imem_resp_valid),
    .i_imem_resp_data (i_imem_resp_data),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_out_instr      (o_out_instr),
    .o_out_pc         (o_out_pc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        pend_q[$];    // accepted requests awaiting their response
  ent_t        fifo_q[$];    // words decode should see, oldest first
  logic [31:0] popped_q[$];  // addresses handed to decode
  int          epoch;
  int          cyc;
  int          lat;
  logic [31:0] pc_reg;

  logic        e_req_valid;
  logic        e_out_valid;
  logic [31:0] e_next_pc;
  logic [31:0] e_out_pc;
  logic [31:0] e_out_instr;
  logic        m_accept;
  logic        m_pop;
  logic        m_resp;

  int compared;
  int mismatched;

  // Drive PC and memory response for this cycle, then derive expectations
  task automatic settle();
    i_pc   = pc_reg;
    m_resp = 1'b0;
    if (pend_q.size() != 0) m_resp = (pend_q[0].due == cyc);
    i_imem_resp_valid = m_resp;
    if (m_resp) i_imem_resp_data = pend_q[0].data;
    else        i_imem_resp_data = $urandom;
    #1;
    e_req_valid = !i_redirect && ((fifo_q.size() + pend_q.size()) < DEPTH);
    m_accept    = e_req_valid && i_imem_req_ready;
    if (i_redirect)    e_next_pc = i_redirect_pc;
    else if (m_accept) e_next_pc = pc_reg + 32'd4;
    else               e_next_pc = pc_reg;
    e_out_valid = (fifo_q.size() != 0);
    e_out_pc    = 32'h0;
    e_out_instr = 32'h0;
    if (e_out_valid) begin
      e_out_pc    = fifo_q[0].pc;
      e_out_instr = fifo_q[0].instr;
    end
    m_pop = e_out_valid && i_out_ready;
  endtask

  // Clock edge: move the model forward by one cycle
  task automatic advance();
    req_t r;
    bit   kept;
    @(posedge i_clock);
    kept = 1'b0;
    if (m_resp) begin
      r    = pend_q.pop_front();
      kept = (r.epoch == epoch) && !i_redirect;
    end
    if (i_redirect) begin
      fifo_q.delete();
      epoch++;
      pc_reg = i_redirect_pc;
    end else begin
      if (m_pop) begin
        popped_q.push_back(fifo_q[0].pc);
        void'(fifo_q.pop_front());
      end
      if (kept) fifo_q.push_back('{r.addr, r.data});
      if (m_accept) pend_q.push_back('{pc_reg, $urandom, epoch, cyc + lat});
      pc_reg = e_next_pc;
    end
    cyc++;
    @(negedge i_clock);
  endtask

  // Reset DUT, memory and model together; returns at a falling edge
  task automatic do_reset();
    i_reset           = 1'b1;
    i_redirect        = 1'b0;
    i_redirect_pc     = 32'h0;
    i_imem_req_ready  = 1'b0;
    i_imem_resp_valid = 1'b0;
    i_out_ready       = 1'b0;
    i_pc              = 32'h0;
    fifo_q.delete();
    pend_q.delete();
    popped_q.delete();
    pc_reg = 32'h0;
    epoch++;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #1;
    compared++;
    if (o_out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_out_valid got=%0b expected=0", o_out_valid);
    end
    do_reset();
    lat = 1;
    i_imem_req_ready = 1'b1;
    settle();
    compared++;
    if ({o_imem_req_valid, o_imem_req_addr, o_next_pc, o_out_valid} !== {1'b1, 32'h0, 32'h4, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_state got req_valid=%0b addr=%h next_pc=%h out_valid=%0b expected 1 00000000 00000004 0",
               o_imem_req_valid, o_imem_req_addr, o_next_pc, o_out_valid);
    end
    advance();
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    i_imem_req_ready = 1'b1;
    i_out_ready      = 1'b1;
    for (int i = 0; i < 24; i++) begin
      settle();
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid}) begin
        mismatched++;
        $display("FAIL stream_ctrl cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b expected %0b %h %0b",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, e_req_valid, e_next_pc, e_out_valid);
      end
      compared++;
      if (o_imem_req_addr !== pc_reg || (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
        mismatched++;
        $display("FAIL stream_data cyc=%0d got addr=%h pc=%h instr=%h expected %h %h %h",
                 cyc, o_imem_req_addr, o_out_pc, o_out_instr, pc_reg, e_out_pc, e_out_instr);
      end
      if (i >= 2) begin
        compared++;
        if ({o_out_valid, o_out_pc, o_next_pc} !== {1'b1, 32'(4 * (i - 2)), pc_reg + 32'd4}) begin
          mismatched++;
          $display("FAIL stream_seq cyc=%0d got out_valid=%0b out_pc=%h next_pc=%h expected 1 %h %h",
                   cyc, o_out_valid, o_out_pc, o_next_pc, 32'(4 * (i - 2)), pc_reg + 32'd4);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1;
    i_imem_req_ready = 1'b1;
    i_out_ready      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid}) begin
        mismatched++;
        $display("FAIL stall_ctrl cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b expected %0b %h %0b",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, e_req_valid, e_next_pc, e_out_valid);
      end
      advance();
    end
    settle();
    compared++;
    if ({o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc} !== {1'b0, 32'h10, 1'b1, 32'h0}) begin
      mismatched++;
      $display("FAIL stall_hold got req_valid=%0b next_pc=%h out_valid=%0b out_pc=%h expected 0 00000010 1 00000000",
               o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc);
    end
    advance();
    i_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      settle();
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid} ||
          (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
        mismatched++;
        $display("FAIL stall_drain cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b pc=%h instr=%h expected %0b %h %0b %h %h",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc, o_out_instr,
                 e_req_valid, e_next_pc, e_out_valid, e_out_pc, e_out_instr);
      end
      advance();
    end
    compared++;
    if (popped_q.size() < 5 || popped_q[0] !== 32'h0 || popped_q[3] !== 32'hC || popped_q[4] !== 32'h10) begin
      mismatched++;
      $display("FAIL stall_order got %0d pops first=%h expected 0,4,8,c,10 in order",
               popped_q.size(), (popped_q.size() != 0) ? popped_q[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    lat = 2;
    for (int i = 0; i < 40; i++) begin
      i_imem_req_ready = (i % 2 == 0);
      i_out_ready      = ($urandom_range(0, 3) != 0);
      settle();
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid} ||
          (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
        mismatched++;
        $display("FAIL bp_cycle cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b pc=%h instr=%h expected %0b %h %0b %h %h",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc, o_out_instr,
                 e_req_valid, e_next_pc, e_out_valid, e_out_pc, e_out_instr);
      end
      advance();
    end
    bad = 0;
    for (int k = 0; k < popped_q.size(); k++) if (popped_q[k] !== 32'(4 * k)) bad++;
    compared++;
    if (bad != 0 || popped_q.size() < 8) begin
      mismatched++;
      $display("FAIL bp_sequence got %0d pops with %0d out of order expected >=8 contiguous from 0",
               popped_q.size(), bad);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3;
    i_imem_req_ready = 1'b1;
    i_out_ready      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid}) begin
        mismatched++;
        $display("FAIL redir_pre cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b expected %0b %h %0b",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, e_req_valid, e_next_pc, e_out_valid);
      end
      advance();
    end
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    settle();
    compared++;
    if ({o_imem_req_valid, o_next_pc} !== {1'b0, 32'h100}) begin
      mismatched++;
      $display("FAIL redir_cycle got req_valid=%0b next_pc=%h expected 0 00000100", o_imem_req_valid, o_next_pc);
    end
    advance();
    i_redirect = 1'b0;
    popped_q.delete();
    for (int i = 0; i < 16; i++) begin
      settle();
      if (i == 0) begin
        compared++;
        if (o_out_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL redir_empty got out_valid=%0b expected 0", o_out_valid);
        end
      end
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid} ||
          (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
        mismatched++;
        $display("FAIL redir_post cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b pc=%h instr=%h expected %0b %h %0b %h %h",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc, o_out_instr,
                 e_req_valid, e_next_pc, e_out_valid, e_out_pc, e_out_instr);
      end
      advance();
    end
    compared++;
    if (popped_q.size() < 2 || popped_q[0] !== 32'h100 || popped_q[1] !== 32'h104) begin
      mismatched++;
      $display("FAIL redir_target got %0d pops first=%h expected 00000100 then 00000104",
               popped_q.size(), (popped_q.size() != 0) ? popped_q[0] : 32'hx);
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    do_reset();
    lat = 2;
    i_imem_req_ready = 1'b1;
    i_out_ready      = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (e_out_valid && m_resp && pend_q.size() >= 2) found = 1'b1;
      else advance();
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL simul_setup got no cycle with pop+response expected one within 10 cycles");
    end else begin
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h2000;
      settle();
      compared++;
      if ({o_next_pc, o_imem_req_valid, o_out_valid} !== {32'h2000, 1'b0, 1'b1}) begin
        mismatched++;
        $display("FAIL simul_cycle got next_pc=%h req_valid=%0b out_valid=%0b expected 00002000 0 1",
                 o_next_pc, o_imem_req_valid, o_out_valid);
      end
      advance();
      i_redirect = 1'b0;
      popped_q.delete();
      for (int i = 0; i < 14; i++) begin
        settle();
        compared++;
        if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid} ||
            (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
          mismatched++;
          $display("FAIL simul_post cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b pc=%h instr=%h expected %0b %h %0b %h %h",
                   cyc, o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc, o_out_instr,
                   e_req_valid, e_next_pc, e_out_valid, e_out_pc, e_out_instr);
        end
        advance();
      end
      compared++;
      if (popped_q.size() == 0 || popped_q[0] !== 32'h2000) begin
        mismatched++;
        $display("FAIL simul_target got %0d pops first=%h expected 00002000",
                 popped_q.size(), (popped_q.size() != 0) ? popped_q[0] : 32'hx);
      end
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    lat = 1;
    i_imem_req_ready = 1'b1;
    i_out_ready      = 1'b1;
    i_redirect       = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFC;
    settle();
    advance();
    i_redirect = 1'b0;
    popped_q.delete();
    for (int i = 0; i < 8; i++) begin
      settle();
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid} ||
          (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
        mismatched++;
        $display("FAIL wrap_cycle cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b pc=%h instr=%h expected %0b %h %0b %h %h",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc, o_out_instr,
                 e_req_valid, e_next_pc, e_out_valid, e_out_pc, e_out_instr);
      end
      advance();
    end
    compared++;
    if (popped_q.size() < 2 || popped_q[0] !== 32'hFFFF_FFFC || popped_q[1] !== 32'h0) begin
      mismatched++;
      $display("FAIL wrap_order got %0d pops first=%h expected fffffffc then 00000000",
               popped_q.size(), (popped_q.size() != 0) ? popped_q[0] : 32'hx);
    end
    // Mid-stream asynchronous reset: out_valid must drop before any clock edge
    settle();
    compared++;
    if (o_out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL areset_pre got out_valid=%0b expected 1", o_out_valid);
    end
    #2 i_reset = 1'b1;
    #1;
    compared++;
    if ({o_out_valid, o_imem_req_valid} !== 2'b01) begin
      mismatched++;
      $display("FAIL areset_now got out_valid=%0b req_valid=%0b expected 0 1", o_out_valid, o_imem_req_valid);
    end
    do_reset();
    i_imem_req_ready = 1'b1;
    i_out_ready      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      compared++;
      if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid} ||
          (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
        mismatched++;
        $display("FAIL areset_restart cyc=%0d got req_valid=%0b next_pc=%h out_valid=%0b pc=%h expected %0b %h %0b %h",
                 cyc, o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc,
                 e_req_valid, e_next_pc, e_out_valid, e_out_pc);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] tmp;
    for (int b = 0; b < 6; b++) begin
      do_reset();
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 60; i++) begin
        tmp              = $urandom;
        i_imem_req_ready = ($urandom_range(0, 3) != 0);
        i_out_ready      = ($urandom_range(0, 2) != 0);
        i_redirect       = ($urandom_range(0, 15) == 0);
        i_redirect_pc    = {tmp[31:2], 2'b00};
        settle();
        compared++;
        if ({o_imem_req_valid, o_next_pc, o_out_valid} !== {e_req_valid, e_next_pc, e_out_valid} ||
            (e_out_valid && {o_out_pc, o_out_instr} !== {e_out_pc, e_out_instr})) begin
          mismatched++;
          $display("FAIL random cyc=%0d lat=%0d got req_valid=%0b next_pc=%h out_valid=%0b pc=%h instr=%h expected %0b %h %0b %h %h",
                   cyc, lat, o_imem_req_valid, o_next_pc, o_out_valid, o_out_pc, o_out_instr,
                   e_req_valid, e_next_pc, e_out_valid, e_out_pc, e_out_instr);
        end
        advance();
      end
      i_redirect = 1'b0;
    end
  endtask

  initial begin
    compared          = 0;
    mismatched        = 0;
    epoch             = 0;
    cyc               = 0;
    lat               = 1;
    pc_reg            = 32'h0;
    i_reset           = 1'b0;
    i_pc              = 32'h0;
    i_redirect        = 1'b0;
    i_redirect_pc     = 32'h0;
    i_imem_req_ready  = 1'b0;
    i_imem_resp_valid = 1'b0;
    i_imem_resp_data  = 32'h0;
    i_out_ready       = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_backpressure();
    test_redirect();
    test_simultaneous();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion by 200000 time units expected summary first");
    $fatal(1);
  end

endmodule
